serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle N-bit subtractor computing {bout,diff} = a - b - bin, DIGIT bits per clock, LSB first.
//  Chains DIGIT full-subtractor cells per cycle and carries the borrow in a flip-flop between cycles.
//  Successor to the single-bit full subtractor (D/B outputs from X,Y,Z); replaces wide ripple-borrow
//  logic in the arithmetic datapath. Start and result sides use valid/ready handshakes.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 2
//  DIGIT  1  bits processed per cycle; must divide WIDTH (elaboration error otherwise)
//  derived: NCYC = WIDTH/DIGIT; counter width = clog2(NCYC)+1
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous, active-low reset
//  start_valid  in   1      operands a, b, bin are valid
//  start_ready  out  1      block can accept operands (IDLE only)
//  a            in   WIDTH  minuend
//  b            in   WIDTH  subtrahend
//  bin          in   1      borrow-in
//  out_valid    out  1      diff/bout/zero valid
//  out_ready    in   1      consumer accepts result
//  diff         out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout         out  1      borrow-out: 1 when a < b + bin (unsigned)
//  zero         out  1      diff == 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, counter=0, borrow reg=0, operand regs=0,
//   diff=0, bout=0, zero=0, out_valid=0. start_ready=1 in the cycle after reset releases.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start_ready=1. start_valid=1 at edge -> capture a, b, bin; counter=0; -> RUN.
//   RUN: start_ready=0. Each edge: low DIGIT bits of the a/b shift regs go through the DIGIT-cell chain
//        with borrow reg as cell-0 borrow-in; results shift into diff from the MSB end; a/b shift right
//        by DIGIT; borrow reg <= chain borrow-out; counter++. After the NCYC-th RUN edge -> DONE.
//   DONE: out_valid=1; diff, bout(=final borrow), zero held stable. out_valid&&out_ready at edge -> IDLE.
//  Latency: operands accepted at edge k -> out_valid high in the cycle after edge k+NCYC.
//   Throughput: one result per NCYC+2 cycles with out_ready held high.
//  Handshake: start_valid outside IDLE is ignored (start_ready=0); the block never drops a result;
//   out_ready low holds DONE indefinitely with outputs frozen.
//  Simultaneous out_ready and start_valid in DONE: result retired and state goes to IDLE; operands are
//   not accepted at that edge (start_ready=0 in DONE) and are taken at the next edge if still valid.
//  diff/bout/zero update only at DONE entry; they hold the last result during IDLE and RUN.
//  Arithmetic: unsigned, modulo 2^WIDTH; bout is the true borrow of the full WIDTH-bit operation.
//  Reset mid-operation (RUN or DONE): partial result discarded, all registers to reset values.
//  Operand changes after acceptance have no effect (operands are registered).
// STRUCTURE
//  Sub-module full_sub_cell: 1-bit combinational cell, inputs x, y, bin_i -> d = x^y^bin_i,
//   bo = (~x & y) | (~(x^y) & bin_i). Instantiated DIGIT times via generate, borrow chained.
//  Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2); no other typedefs.
//  Top: FSM + counter, a/b shift regs, diff shift reg, borrow flop, output flags.
// TESTING
//  W=8,D=1: a=0x05,b=0x03,bin=0 accepted at edge k -> out_valid in cycle after k+8, diff=0x02,bout=0,zero=0.
//  W=8,D=1: a=0x03,b=0x05,bin=0 -> diff=0xFE,bout=1; a=0x00,b=0x00,bin=1 -> diff=0xFF,bout=1.
//  W=8,D=1: a=b=0xA5,bin=0 -> diff=0x00,bout=0,zero=1; then out_ready=0 for 5 cycles -> outputs stable, start_ready=0.
//  Reset asserted at 3rd RUN cycle -> next cycle IDLE, out_valid=0, diff=0; new a=0x10,b=0x01 -> diff=0x0F.
//  W=8,D=4: a=0x80,b=0x01,bin=0 -> out_valid in cycle after k+2, diff=0x7F,bout=0.
//  W=4,D=1 and D=2: exhaustive a,b,bin vs behavioural a-b-bin, random out_ready back-pressure; no lost/duplicate results.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin_i, bo is the borrow out of this bit.
// Latency: combinational.
// Backpressure: none.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin_i,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin_i;
    assign bo = (~x & y) | (~(x ^ y) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor {bout,diff} = a - b - bin, DIGIT bits per clock, LSB first.
// Latency: accepted at edge k -> out_valid in the cycle after edge k+WIDTH/DIGIT.
// Backpressure: start_ready only in IDLE; result held in DONE until out_ready.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = $clog2(NCYC) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             brw;

    logic [DIGIT-1:0]       chain_d;
    logic [DIGIT:0]         chain_b;
    logic [WIDTH+DIGIT-1:0] diff_cat;
    logic [WIDTH-1:0]       diff_nxt;

    assign chain_b[0] = brw;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_sub_cell u_cell (
            .x     (a_sr[i]),
            .y     (b_sr[i]),
            .bin_i (chain_b[i]),
            .d     (chain_d[i]),
            .bo    (chain_b[i+1])
        );
    end

    // New digits enter at the MSB end so the LSB digit lands in place after NCYC shifts.
    assign diff_cat = {chain_d, diff_sr};
    assign diff_nxt = diff_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            diff_sr     <= '0;
            brw         <= 1'b0;
            diff        <= '0;
            bout        <= 1'b0;
            zero        <= 1'b0;
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr        <= a;
                        b_sr        <= b;
                        brw         <= bin;
                        diff_sr     <= '0;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> DIGIT;
                    b_sr    <= b_sr >> DIGIT;
                    brw     <= chain_b[DIGIT];
                    diff_sr <= diff_nxt;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        diff      <= diff_nxt;
                        bout      <= chain_b[DIGIT];
                        zero      <= (diff_nxt == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // start_ready stays low here, so a concurrent start waits one edge.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid   <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic       w8_sv   [2];
    logic       w8_srdy [2];
    logic [7:0] w8_a    [2];
    logic [7:0] w8_b    [2];
    logic       w8_bin  [2];
    logic       w8_ov   [2];
    logic       w8_or   [2];
    logic [7:0] w8_diff [2];
    logic       w8_bout [2];
    logic       w8_zero [2];

    logic       w4_sv   [2];
    logic       w4_srdy [2];
    logic [3:0] w4_a    [2];
    logic [3:0] w4_b    [2];
    logic       w4_bin  [2];
    logic       w4_ov   [2];
    logic       w4_or   [2];
    logic [3:0] w4_diff [2];
    logic       w4_bout [2];
    logic       w4_zero [2];

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start_valid(w8_sv[0]), .start_ready(w8_srdy[0]),
        .a(w8_a[0]), .b(w8_b[0]), .bin(w8_bin[0]), .out_valid(w8_ov[0]), .out_ready(w8_or[0]),
        .diff(w8_diff[0]), .bout(w8_bout[0]), .zero(w8_zero[0]));

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start_valid(w8_sv[1]), .start_ready(w8_srdy[1]),
        .a(w8_a[1]), .b(w8_b[1]), .bin(w8_bin[1]), .out_valid(w8_ov[1]), .out_ready(w8_or[1]),
        .diff(w8_diff[1]), .bout(w8_bout[1]), .zero(w8_zero[1]));

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst_n(rst_n), .start_valid(w4_sv[0]), .start_ready(w4_srdy[0]),
        .a(w4_a[0]), .b(w4_b[0]), .bin(w4_bin[0]), .out_valid(w4_ov[0]), .out_ready(w4_or[0]),
        .diff(w4_diff[0]), .bout(w4_bout[0]), .zero(w4_zero[0]));

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start_valid(w4_sv[1]), .start_ready(w4_srdy[1]),
        .a(w4_a[1]), .b(w4_b[1]), .bin(w4_bin[1]), .out_valid(w4_ov[1]), .out_ready(w4_or[1]),
        .diff(w4_diff[1]), .bout(w4_bout[1]), .zero(w4_zero[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; hold = cycles out_ready stays low once the result is up.
    task automatic run8(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] exp_diff, input logic exp_bout, input logic exp_zero,
                        input int hold);
        int n;
        int exp_lat;
        exp_lat = (sel == 0) ? 8 : 2;
        n = 0;
        while (!w8_srdy[sel] && n < 50) begin
            step();
            n++;
        end
        check("run8_start_ready", 32'(w8_srdy[sel]), 32'd1);
        w8_or[sel]  = (hold == 0);
        w8_a[sel]   = a;
        w8_b[sel]   = b;
        w8_bin[sel] = bin;
        w8_sv[sel]  = 1'b1;
        step();
        w8_sv[sel]  = 1'b0;
        w8_a[sel]   = ~a;
        w8_b[sel]   = ~b;
        check("run8_busy", 32'(w8_srdy[sel]), 32'd0);
        n = 0;
        while (!w8_ov[sel] && n < 50) begin
            step();
            n++;
        end
        check("run8_latency", 32'(n), 32'(exp_lat));
        check("run8_diff", 32'(w8_diff[sel]), 32'(exp_diff));
        check("run8_bout", 32'(w8_bout[sel]), 32'(exp_bout));
        check("run8_zero", 32'(w8_zero[sel]), 32'(exp_zero));
        for (int i = 0; i < hold; i++) begin
            w8_sv[sel] = 1'b1;
            step();
            check("hold_valid", 32'(w8_ov[sel]), 32'd1);
            check("hold_diff", 32'(w8_diff[sel]), 32'(exp_diff));
            check("hold_zero", 32'(w8_zero[sel]), 32'(exp_zero));
            check("hold_start_ready", 32'(w8_srdy[sel]), 32'd0);
        end
        w8_sv[sel] = 1'b0;
        w8_or[sel] = 1'b1;
        step();
        check("run8_retired", 32'(w8_ov[sel]), 32'd0);
        check("run8_idle_ready", 32'(w8_srdy[sel]), 32'd1);
    endtask

    // Exhaustive WIDTH=4 sweep with random out_ready back-pressure.
    task automatic ex4(input int sel);
        int n;
        int dd;
        logic done;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    dd = a - b - bi;
                    n = 0;
                    while (!w4_srdy[sel] && n < 50) begin
                        step();
                        n++;
                    end
                    w4_a[sel]   = 4'(a);
                    w4_b[sel]   = 4'(b);
                    w4_bin[sel] = 1'(bi);
                    w4_sv[sel]  = 1'b1;
                    step();
                    w4_sv[sel] = 1'b0;
                    done = 1'b0;
                    n = 0;
                    while (!done && n < 100) begin
                        w4_or[sel] = 1'($urandom_range(0, 1));
                        if (w4_ov[sel] && w4_or[sel]) begin
                            check("ex4_diff", 32'(w4_diff[sel]), 32'(dd & 15));
                            check("ex4_bout", 32'(w4_bout[sel]), 32'(dd < 0));
                            check("ex4_zero", 32'(w4_zero[sel]), 32'((dd & 15) == 0));
                            done = 1'b1;
                        end
                        step();
                        n++;
                    end
                    if (!done) check("ex4_timeout", 32'd0, 32'd1);
                    check("ex4_no_dup", 32'(w4_ov[sel]), 32'd0);
                end
            end
        end
        w4_or[sel] = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w8_sv[i] = 1'b0; w8_a[i] = '0; w8_b[i] = '0; w8_bin[i] = 1'b0; w8_or[i] = 1'b1;
            w4_sv[i] = 1'b0; w4_a[i] = '0; w4_b[i] = '0; w4_bin[i] = 1'b0; w4_or[i] = 1'b1;
        end
        step();
        step();
        check("rst_out_valid", 32'(w8_ov[0]), 32'd0);
        check("rst_diff", 32'(w8_diff[0]), 32'd0);
        check("rst_bout", 32'(w8_bout[0]), 32'd0);
        check("rst_zero", 32'(w8_zero[0]), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_start_ready", 32'(w8_srdy[0]), 32'd1);

        run8(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
        run8(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
        run8(0, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 5);
        run8(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);

        // Abort in the third RUN cycle; the stale 0xFF result must be cleared.
        w8_a[0] = 8'h55; w8_b[0] = 8'h11; w8_bin[0] = 1'b0; w8_sv[0] = 1'b1;
        step();
        w8_sv[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(w8_ov[0]), 32'd0);
        check("midrst_diff", 32'(w8_diff[0]), 32'd0);
        check("midrst_bout", 32'(w8_bout[0]), 32'd0);
        check("midrst_start_ready", 32'(w8_srdy[0]), 32'd1);
        step();
        run8(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

        run8(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        run8(1, 8'h12, 8'h34, 1'b1, 8'hDD, 1'b1, 1'b0, 2);

        ex4(0);
        ex4(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
